// File: rtl/recepcion_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : recepcion_cfg
//  Purpose  : Configurable UART receiver with 3-sample majority voting.
//  Revision : 1.0 - initial release
// ============================================================================
module recepcion_cfg #(
  parameter int DIV       = 4,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rcv,
  output logic                 rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic                 clk_div
);

  localparam int c_DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_SW = $clog2(OVS);
  localparam int c_BW = $clog2(DATA_BITS);

  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(DIV - 1);
  localparam logic [c_SW-1:0] c_S_LO     = c_SW'(OVS / 2 - 1);
  localparam logic [c_SW-1:0] c_S_MD     = c_SW'(OVS / 2);
  localparam logic [c_SW-1:0] c_S_HI     = c_SW'(OVS / 2 + 1);
  localparam logic [c_SW-1:0] c_S_LAST   = c_SW'(OVS - 1);
  localparam logic [c_BW-1:0] c_B_DLAST  = c_BW'(DATA_BITS - 1);
  localparam logic [c_BW-1:0] c_B_SLAST  = c_BW'(STOP_BITS - 1);
  localparam logic            c_ODD      = (PARITY == 2);
  localparam logic            c_HAS_PAR  = (PARITY != 0);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_START = 3'd1;
  localparam logic [2:0] c_ST_DATA  = 3'd2;
  localparam logic [2:0] c_ST_PAR   = 3'd3;
  localparam logic [2:0] c_ST_STOP  = 3'd4;

  logic                 r_rx_meta;
  logic                 r_rxs;
  logic [c_DW-1:0]      r_div_cnt;
  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [c_SW-1:0]      r_s;
  logic [c_BW-1:0]      r_b;
  logic [1:0]           r_smp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr_int;
  logic                 r_ferr_int;
  logic                 w_tick;
  logic                 w_mid;
  logic                 w_last;
  logic                 w_maj;
  logic                 w_done;
  logic                 w_par_exp;

  // Both stages reset high so the idle line is not mistaken for a start bit.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset || w_tick) r_div_cnt <= '0;
    else                 r_div_cnt <= r_div_cnt + 1'b1;
  end

  assign w_tick    = (r_div_cnt == c_DIV_LAST);
  assign clk_div   = w_tick;
  assign w_mid     = (r_s == c_S_HI);
  assign w_last    = (r_s == c_S_LAST);
  // Third vote is the live synchronized sample at the decision point.
  assign w_maj     = (r_smp[1] & r_smp[0]) | (r_smp[1] & r_rxs) | (r_smp[0] & r_rxs);
  assign w_par_exp = (^r_shift) ^ c_ODD;

  always_ff @(posedge clk_in) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    if (w_tick) begin
      case (r_state)
        c_ST_IDLE:  if (!r_rxs) w_state_nxt = c_ST_START;
        c_ST_START: begin
          if (w_mid && w_maj) w_state_nxt = c_ST_IDLE;
          else if (w_last)    w_state_nxt = c_ST_DATA;
        end
        c_ST_DATA:  if (w_last && (r_b == c_B_DLAST))
                      w_state_nxt = c_HAS_PAR ? c_ST_PAR : c_ST_STOP;
        c_ST_PAR:   if (w_last) w_state_nxt = c_ST_STOP;
        c_ST_STOP: begin
          if (w_mid && (r_b == c_B_SLAST)) begin
            w_state_nxt = c_ST_IDLE;
            w_done      = 1'b1;
          end
        end
        default:    w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state != c_ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_s        <= '0;
      r_b        <= '0;
      r_smp      <= '0;
      r_shift    <= '0;
      r_perr_int <= 1'b0;
      r_ferr_int <= 1'b0;
      dout       <= '0;
      rcv        <= 1'b0;
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rcv     <= 1'b0;
      overrun <= 1'b0;
      if (ack) rdy <= 1'b0;
      if (w_tick) begin
        if ((w_state_nxt != r_state) || (r_state == c_ST_IDLE)) begin
          r_s <= '0;
          r_b <= '0;
        end else if (w_last) begin
          r_s <= '0;
          r_b <= r_b + 1'b1;
        end else begin
          r_s <= r_s + 1'b1;
        end
        if (r_s == c_S_LO) r_smp[1] <= r_rxs;
        if (r_s == c_S_MD) r_smp[0] <= r_rxs;
        case (r_state)
          c_ST_IDLE: begin
            r_perr_int <= 1'b0;
            r_ferr_int <= 1'b0;
          end
          c_ST_DATA: if (w_mid) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          c_ST_PAR:  if (w_mid) r_perr_int <= w_maj ^ w_par_exp;
          c_ST_STOP: if (w_mid && !w_maj) r_ferr_int <= 1'b1;
          default:   ;
        endcase
        // Completion overrides a coincident ack so the new word is never lost.
        if (w_done) begin
          dout       <= r_shift;
          parity_err <= c_HAS_PAR & r_perr_int;
          frame_err  <= r_ferr_int | ~w_maj;
          rcv        <= 1'b1;
          overrun    <= rdy;
          rdy        <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
